// File: rtl/seq_add_two_nums.sv
`default_nettype none
// ============================================================================
//  Module      : seq_add_two_nums
//  Description : Multi-cycle WIDTH-bit adder computing {c_out, sum} =
//                in1 + in2 + c_in one SLICE-bit slice per clock, with the
//                carry registered between slices and a start/done handshake.
//                Feeding in2 = ~b with c_in = 1 gives in1 - b, which matches
//                the combinational subtractor for cross-checking.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_add_two_nums #(
    parameter int WIDTH = 64,
    parameter int SLICE = 8     // must divide WIDTH exactly
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy,
    output logic             done
);

    localparam int c_NUM_SLICES = WIDTH / SLICE;
    localparam int c_IDX_W      = (c_NUM_SLICES > 1) ? $clog2(c_NUM_SLICES) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NUM_SLICES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_carry;
    logic [c_IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_c_out;
    logic [SLICE-1:0]     w_a_slice;
    logic [SLICE-1:0]     w_b_slice;
    logic [SLICE:0]       w_slice_sum;
    logic                 w_last;

    assign w_last = (r_idx == c_LAST_IDX);

    // Select the operand slices addressed by the current slice index.
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int i = 0; i < c_NUM_SLICES; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_a_slice = r_a[i*SLICE +: SLICE];
                w_b_slice = r_b[i*SLICE +: SLICE];
            end
        end
    end

    // One slice of the addition; the MSB is the carry into the next slice.
    assign w_slice_sum = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{SLICE{1'b0}}, r_carry};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start is only looked at in IDLE, DONE lasts one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: capture operands on accept, add one slice per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= in1;
                        r_b     <= in2;
                        r_carry <= c_in;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_c_out <= 1'b0;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < c_NUM_SLICES; i++) begin
                        if (r_idx == c_IDX_W'(i)) begin
                            r_sum[i*SLICE +: SLICE] <= w_slice_sum[SLICE-1:0];
                        end
                    end
                    r_carry <= w_slice_sum[SLICE];
                    if (w_last) begin
                        r_c_out <= w_slice_sum[SLICE];
                        r_idx   <= '0;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                    end
                end
                default: ;  // DONE: result is held
            endcase
        end
    end

    assign sum   = r_sum;
    assign c_out = r_c_out;
    assign busy  = (r_state == S_RUN);
    assign done  = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_add_two_nums.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_add_two_nums
//  Description : Self-checking bench for seq_add_two_nums. Expected results
//                are queued when a request is driven and compared at done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_add_two_nums;

    localparam int WIDTH = 64;
    localparam int SLICE = 8;
    localparam int MAX_EDGES = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             c_in;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             busy;
    logic             done;

    int               n_vec = 0;
    int               n_err = 0;
    logic [WIDTH:0]   sb_q[$];

    seq_add_two_nums #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .c_in  (c_in),
        .sum   (sum),
        .c_out (c_out),
        .busy  (busy),
        .done  (done)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait for done, counting edges from the accepting edge (already counted).
    task automatic wait_done(inout int edges);
        while (done !== 1'b1 && edges < MAX_EDGES) begin
            tick();
            edges++;
        end
    endtask

    // Full transaction: accept, check latency and result, check hold.
    task automatic do_op(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic ci,
                         input logic [WIDTH:0] exp);
        int          edges;
        logic [WIDTH:0] e;
        in1   = a;
        in2   = b;
        c_in  = ci;
        start = 1'b1;
        sb_q.push_back(exp);
        tick();
        start = 1'b0;
        in1   = ~a;      // operands must have been captured at the accept edge
        in2   = ~b;
        c_in  = ~ci;
        chk("busy_after_accept", (WIDTH+1)'(busy), (WIDTH+1)'(1));
        chk("cleared_on_accept", {c_out, sum}, '0);
        edges = 1;
        wait_done(edges);
        chk("latency", (WIDTH+1)'(edges), (WIDTH+1)'(9));
        e = sb_q.pop_front();
        chk(tag, {c_out, sum}, e);
        tick();
        chk("done_one_cycle", (WIDTH+1)'({busy, done}), '0);
        chk("result_held", {c_out, sum}, e);
    endtask

    initial begin
        int             edges;
        int             n_seen;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH:0]   e;

        rst   = 1'b1;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        c_in  = 1'b0;
        tick();
        tick();
        chk("reset_result", {c_out, sum}, '0);
        chk("reset_flags", (WIDTH+1)'({busy, done}), '0);
        rst = 1'b0;
        tick();

        // Basic and carry-ripple cases.
        do_op("basic_add", 64'h5, 64'h3, 1'b0, {1'b0, 64'h8});
        do_op("ripple_all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, {1'b1, 64'h0});
        do_op("msb_carry", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
              {1'b1, 64'h0});

        // Subtractor equivalence; issued back to back (start the cycle after done).
        do_op("sub_100_58", 64'd100, ~64'd58, 1'b1, {1'b1, 64'd42});
        do_op("sub_5_7", 64'd5, ~64'd7, 1'b1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});

        // Start while busy: the second request is dropped.
        in1   = 64'd1;
        in2   = 64'd1;
        c_in  = 1'b0;
        start = 1'b1;
        sb_q.push_back({1'b0, 64'd2});
        tick();
        start = 1'b0;
        tick();
        tick();
        in1   = 64'd9;
        in2   = 64'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 4;
        wait_done(edges);
        chk("busy_latency", (WIDTH+1)'(edges), (WIDTH+1)'(9));
        e = sb_q.pop_front();
        chk("busy_drop_sum", {c_out, sum}, e);
        n_seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) n_seen++;
        end
        chk("busy_no_second_op", (WIDTH+1)'(n_seen), '0);

        // Reset in the middle of RUN discards the operation.
        in1   = 64'h1234_5678_9ABC_DEF0;
        in2   = 64'h0FED_CBA9_8765_4321;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_result", {c_out, sum}, '0);
        chk("rst_mid_flags", (WIDTH+1)'({busy, done}), '0);
        start = 1'b1;    // reset wins over a simultaneous start
        tick();
        chk("rst_beats_start", (WIDTH+1)'({busy, done}), '0);
        rst   = 1'b0;
        start = 1'b0;
        n_seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) n_seen++;
        end
        chk("rst_no_done", (WIDTH+1)'(n_seen), '0);
        do_op("after_reset", 64'hFFFF_0000_FFFF_0000, 64'h0001_FFFF_0001_FFFF, 1'b1,
              {1'b1, 64'h0001_0000_0001_0000});

        // Random cross-check against subtraction a - b.
        for (int k = 0; k < 1000; k++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (k % 8 == 0) b = a;
            e = {(a >= b), a - b};
            do_op("rand_sub", a, ~b, 1'b1, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
